// File: rtl/ras_controller.sv
// Return address stack sequencer for the fetch-stage predictor.
// Arbitrates two fetch slots onto one speculative stack, tracks a committed
// pointer/count retired from EX, and restores speculative state on flush.
// Optional build macro RAS_COMMIT_STACK_EN adds a committed copy of the array
// that is restored wholesale into the speculative array on flush.
module ras_controller #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  logic             push0,
  input  logic             pop0,
  input  logic [31:0]      push_addr0,
  input  logic             push1,
  input  logic             pop1,
  input  logic [31:0]      push_addr1,
  input  logic             commit_push,
  input  logic             commit_pop,
  input  logic [31:0]      commit_addr,
  input  logic             flush,
  output logic             ret_valid,
  output logic [31:0]      ret_target,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0]   CntMax = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

  logic [31:0]      stack_q [DEPTH];

  logic [PTR_W-1:0] spec_top_q, spec_top_d;
  logic [PTR_W:0]   spec_cnt_q, spec_cnt_d;
  logic [PTR_W-1:0] commit_top_q, commit_top_d;
  logic [PTR_W:0]   commit_cnt_q, commit_cnt_d;
  logic             ret_valid_q, ret_valid_d;
  logic [31:0]      ret_target_q, ret_target_d;

  logic             use_slot0;
  logic             sel_push, sel_pop;
  logic [31:0]      sel_addr;
  logic             spec_we;
  logic [PTR_W-1:0] spec_waddr;
  logic             commit_we;
  logic [PTR_W-1:0] commit_waddr;

  // Slot arbitration: slot0 is older, so any slot0 activity wins the cycle.
  always_comb begin
    use_slot0 = push0 | pop0;
    sel_push  = use_slot0 ? push0 : push1;
    sel_pop   = use_slot0 ? pop0 : pop1;
    sel_addr  = use_slot0 ? push_addr0 : push_addr1;
  end

  // Committed pointer/count next state; same push/pop rules as the speculative side.
  always_comb begin
    commit_top_d = commit_top_q;
    commit_cnt_d = commit_cnt_q;
    commit_we    = 1'b0;
    commit_waddr = commit_top_q + PtrOne;
    case ({commit_push, commit_pop})
      2'b10: begin
        commit_we    = 1'b1;
        commit_top_d = commit_top_q + PtrOne;
        if (commit_cnt_q != CntMax) commit_cnt_d = commit_cnt_q + CntOne;
      end
      2'b01: begin
        if (commit_cnt_q != '0) begin
          commit_top_d = commit_top_q - PtrOne;
          commit_cnt_d = commit_cnt_q - CntOne;
        end
      end
      2'b11: begin
        // Return+call retires in place: the top entry is replaced.
        commit_we    = 1'b1;
        commit_waddr = commit_top_q;
        if (commit_cnt_q == '0) commit_cnt_d = CntOne;
      end
      default: ;
    endcase
  end

  // Speculative next state; flush reloads from the post-commit values.
  always_comb begin
    spec_top_d   = spec_top_q;
    spec_cnt_d   = spec_cnt_q;
    ret_valid_d  = 1'b0;
    ret_target_d = ret_target_q;
    spec_we      = 1'b0;
    spec_waddr   = spec_top_q + PtrOne;
    if (flush) begin
      spec_top_d = commit_top_d;
      spec_cnt_d = commit_cnt_d;
    end else if (!stall) begin
      case ({sel_push, sel_pop})
        2'b10: begin
          spec_we    = 1'b1;
          spec_top_d = spec_top_q + PtrOne;
          // Full push wraps onto the oldest entry; count saturates.
          if (spec_cnt_q != CntMax) spec_cnt_d = spec_cnt_q + CntOne;
        end
        2'b01: begin
          if (spec_cnt_q != '0) begin
            ret_valid_d  = 1'b1;
            ret_target_d = stack_q[spec_top_q];
            spec_top_d   = spec_top_q - PtrOne;
            spec_cnt_d   = spec_cnt_q - CntOne;
          end
        end
        2'b11: begin
          ret_valid_d  = (spec_cnt_q != '0);
          ret_target_d = stack_q[spec_top_q];
          spec_we      = 1'b1;
          spec_waddr   = spec_top_q;
          if (spec_cnt_q == '0) spec_cnt_d = CntOne;
        end
        default: ;
      endcase
    end
  end

  // Pointer, count and return-target registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      spec_top_q   <= PTR_W'(DEPTH - 1);
      commit_top_q <= PTR_W'(DEPTH - 1);
      spec_cnt_q   <= '0;
      commit_cnt_q <= '0;
      ret_valid_q  <= 1'b0;
      ret_target_q <= '0;
    end else begin
      spec_top_q   <= spec_top_d;
      commit_top_q <= commit_top_d;
      spec_cnt_q   <= spec_cnt_d;
      commit_cnt_q <= commit_cnt_d;
      ret_valid_q  <= ret_valid_d;
      ret_target_q <= ret_target_d;
    end
  end

`ifdef RAS_COMMIT_STACK_EN
  logic [31:0] committed_q [DEPTH];

  // Committed array tracks retired calls only.
  always_ff @(posedge clk) begin
    if (resetn && commit_we) committed_q[commit_waddr] <= commit_addr;
  end

  // Speculative array; on flush it is rebuilt from the committed array,
  // including any call retiring in the same cycle.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= committed_q[i];
        if (commit_we) stack_q[commit_waddr] <= commit_addr;
      end else if (spec_we) begin
        stack_q[spec_waddr] <= sel_addr;
      end
    end
  end
`else
  logic unused_commit;
  assign unused_commit = ^{commit_we, commit_waddr, commit_addr};

  // Speculative array; flush leaves wrong-path writes in place.
  always_ff @(posedge clk) begin
    if (resetn && spec_we) stack_q[spec_waddr] <= sel_addr;
  end
`endif

  assign ret_valid  = ret_valid_q;
  assign ret_target = ret_target_q;
  assign count      = spec_cnt_q;
  assign full       = (spec_cnt_q == CntMax);
  assign empty      = (spec_cnt_q == '0);

endmodule
